// File: rtl/csa_stream_accumulator.sv
// csa_stream_accumulator: carry-save packet accumulator with valid/ready in/out streams.
// Define CSA_FAST_RESOLVE_EN for a one-cycle S+C resolve instead of iterative carry propagation.
module csa_stream_accumulator #(
  parameter int IN_W  = 4,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IN_W+CNT_W-1:0]  out_sum,
  output logic [CNT_W-1:0]       out_count,
  output logic                   out_trunc
);
  localparam int ACC_W = IN_W + CNT_W;
  localparam logic [CNT_W-1:0] MAX_OPS = '1;
  typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} state_t;
  state_t state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d, c_q, c_d, sum_q, sum_d, x;
  logic [CNT_W-1:0] cnt_q, cnt_d, ocnt_q, ocnt_d, cnt_inc;
  logic trunc_q, trunc_d, otrunc_q, otrunc_d;
  assign x         = {{CNT_W{1'b0}}, in_data};
  assign cnt_inc   = cnt_q + 1'b1;
  assign in_ready  = state_q == ACCUM;
  assign out_valid = state_q == DONE;
  assign out_sum   = sum_q;
  assign out_count = ocnt_q;
  assign out_trunc = otrunc_q;
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    trunc_d  = trunc_q;
    sum_d    = sum_q;
    ocnt_d   = ocnt_q;
    otrunc_d = otrunc_q;
    case (state_q)
      ACCUM: if (in_valid) begin
        s_d     = s_q ^ c_q ^ x;
        c_d     = ((s_q & c_q) | (s_q & x) | (c_q & x)) << 1;
        cnt_d   = cnt_inc;
        trunc_d = cnt_inc == MAX_OPS && !in_last;
        state_d = (in_last || cnt_inc == MAX_OPS) ? RESOLVE : ACCUM;
      end
`ifdef CSA_FAST_RESOLVE_EN
      RESOLVE: begin
        sum_d    = s_q + c_q;
        ocnt_d   = cnt_q;
        otrunc_d = trunc_q;
        state_d  = DONE;
      end
`else
      RESOLVE: if (c_q == '0) begin
        sum_d    = s_q;
        ocnt_d   = cnt_q;
        otrunc_d = trunc_q;
        state_d  = DONE;
      end else begin
        s_d = s_q ^ c_q;
        c_d = (s_q & c_q) << 1;
      end
`endif
      DONE: if (out_ready) begin
        s_d     = '0;
        c_d     = '0;
        cnt_d   = '0;
        trunc_d = 1'b0;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ACCUM;
      s_q      <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      trunc_q  <= 1'b0;
      sum_q    <= '0;
      ocnt_q   <= '0;
      otrunc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      trunc_q  <= trunc_d;
      sum_q    <= sum_d;
      ocnt_q   <= ocnt_d;
      otrunc_q <= otrunc_d;
    end
  end
endmodule

// File: doc/csa_stream_accumulator.md
Name: csa_stream_accumulator

Overview:
- Sequential multi-operand accumulator that sits directly upstream of the 4-bit carry-save adder stage. It consumes a packet of unsigned operands over a valid/ready stream.
- Operands are reduced in redundant carry-save form, one 3:2 compression per cycle, and held in a sum vector S and a carry vector C.
- On the last operand, S and C are resolved to a binary result over one or more cycles. The result is presented on a valid/ready output port.

Parameters:
- IN_W, 4, operand width in bits.
- CNT_W, 4, operand-counter width. A packet holds at most MAX_OPS = 2^CNT_W-1 operands.
- ACC_W (localparam), IN_W+CNT_W, width of accumulator and result. Guarantees no arithmetic overflow for any packet of at most MAX_OPS operands.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand.
- in_data  in  IN_W  unsigned operand.
- in_last  in  1  marks the final operand of a packet.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  ACC_W  resolved packet sum.
- out_count  out  CNT_W  number of operands accepted in the packet.
- out_trunc  out  1  packet was force-terminated at MAX_OPS without in_last.

Behaviour:
- Reset (async assert, sync release): state=ACCUM; S=0, C=0, count=0; in_ready=1; out_valid=0, out_sum=0, out_count=0, out_trunc=0. Reset mid-packet or mid-resolve discards all partial data.
- States:
  - ACCUM: in_ready=1.
  - RESOLVE: in_ready=0.
  - DONE: in_ready=0, out_valid=1.
- ACCUM, operand accepted (in_valid&in_ready):
  - S' = S^C^x and C' = ((S&C)|(S&x)|(C&x))<<1, with x = zero-extended in_data.
  - count' = count+1.
  - Go to RESOLVE if in_last=1 or count'==MAX_OPS. Set trunc if count'==MAX_OPS and in_last=0.
- ACCUM with no handshake: registers hold.
- RESOLVE, each cycle:
  - If C==0: out_sum<=S, out_count<=count, out_trunc<=trunc; go to DONE.
  - Else: S'=S^C, C'=(S&C)<<1. Terminates in at most ACC_W iterations.
- Invariant: no set bit is ever shifted out of the MSB of C. Bench asserts this.
- DONE: outputs held stable while out_ready=0. On out_valid&out_ready: clear S, C, count and trunc; go to ACCUM; in_ready=1 the next cycle.
- Latency: last operand accepted at cycle T. out_valid rises at T+2+k, where k is the number of carry-propagation iterations needed.
- Throughput: no operand accepted from the last-accept cycle until the cycle after the output handshake. There is no overlap between packets.
- in_data and in_last are ignored when in_valid=0. Every packet has at least one operand, because in_last travels with data.

Optional Feature:
- Macro: CSA_FAST_RESOLVE_EN.
- When defined: RESOLVE lasts exactly one cycle, with out_sum<=S+C through a full ACC_W-bit adder. Fixed latency; out_valid rises at T+2.
- When undefined: iterative resolve as described in Behaviour. Smaller area, variable latency.
- Handshake, count and trunc behaviour are identical in both builds.

Test Plan:
- Single operand 9 with in_last=1 -> C==0 at first RESOLVE cycle; out_valid at T+2; out_sum=9, out_count=1, out_trunc=0.
- Operands 15, 15, 15 (last on 3rd) -> out_sum=45, out_count=3, out_trunc=0. Never any MSB carry loss.
- 15 operands of 15, all with in_last=0 -> forced termination after the 15th; in_ready=0; out_sum=225, out_count=15, out_trunc=1.
- Packet 7, 8 (last), then out_ready held low 5 cycles -> out_sum=15 held stable and out_valid=1 throughout; in_ready=0; accept resumes the cycle after out_ready=1.
- rst pulsed during RESOLVE of packet 5, 11 -> all outputs 0 immediately, no out_valid. Next packet 3, 4 (last) -> out_sum=7, out_count=2.
- With CSA_FAST_RESOLVE_EN: packets 1, 1, 1 (last) and 15, 15 (last) -> each out_valid exactly at T+2, out_sum=3 and 30.
